duc_frame_scheduler: RTL

- Sequences one OFDM TX frame from the IFFT/CP sample source into the DUC.
- On `start`, latches the frame configuration, drives the DUC/DDC rate ports, and waits a settle period.
- Then passes exactly num_sym*(nfft+cp_len) IQ beats, generates `tlast` and symbol markers, and appends zero guard beats to flush the CIC/FIR chain.
- Sits between the sample source and the DUC_DDC datapath's `S_AXIS` port; reports busy/done/error status.

---
 rtl/duc_sched_pkg.sv | 18 +
 rtl/duc_frame_counter.sv | 63 ++++++
 rtl/duc_frame_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/duc_sched_pkg.sv
// rtl/duc_sched_pkg.sv - shared types and constants for the DUC frame scheduler
// Purpose: frame-scheduler FSM state encoding and default frame/rate constants.
// Ports: none (package).
package duc_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      STREAM,
      GUARD,
      DONE
   } state_t;

   localparam logic [15:0] DEFAULT_RATE = 16'd40;
   localparam int          DEFAULT_NFFT = 4096;
   localparam int          DEFAULT_CP   = 256;

endpackage

// File: rtl/duc_frame_counter.sv
// rtl/duc_frame_counter.sv - sample/symbol position counter for one OFDM frame
// Purpose: tracks the sample index inside the current symbol and the symbol index
//          inside the frame, advancing only on accepted beats.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clr            return both counters to zero (held while the scheduler is idle)
//   beat           one accepted output beat this cycle
//   sym_len        samples per symbol (nfft + cp_len), LEN_W+1 bits
//   num_sym        symbols per frame (non-zero)
//   first_beat     current position is the first sample of a symbol
//   last_beat      current position is the final sample of the frame
module duc_frame_counter #(
   parameter int LEN_W = 16,
   parameter int SYM_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             beat,
   input  logic [LEN_W:0]   sym_len,
   input  logic [SYM_W-1:0] num_sym,
   output logic             first_beat,
   output logic             last_beat
);

   localparam logic [LEN_W:0]   ONE_L = (LEN_W+1)'(1);
   localparam logic [SYM_W-1:0] ONE_S = SYM_W'(1);

   logic [LEN_W:0]   samp_cnt_q, samp_cnt_d;
   logic [SYM_W-1:0] sym_cnt_q,  sym_cnt_d;
   logic             last_samp;

   assign last_samp  = (samp_cnt_q == sym_len - ONE_L);
   assign first_beat = (samp_cnt_q == '0);
   assign last_beat  = last_samp && (sym_cnt_q == num_sym - ONE_S);

   always_comb begin
      samp_cnt_d = samp_cnt_q;
      sym_cnt_d  = sym_cnt_q;
      if (clr) begin
         samp_cnt_d = '0;
         sym_cnt_d  = '0;
      end else if (beat) begin
         if (last_samp) begin
            samp_cnt_d = '0;
            sym_cnt_d  = sym_cnt_q + ONE_S;
         end else begin
            samp_cnt_d = samp_cnt_q + ONE_L;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         samp_cnt_q <= '0;
         sym_cnt_q  <= '0;
      end else begin
         samp_cnt_q <= samp_cnt_d;
         sym_cnt_q  <= sym_cnt_d;
      end
   end

endmodule

// File: rtl/duc_frame_scheduler.sv
// rtl/duc_frame_scheduler.sv - sequences one OFDM TX frame from the IFFT/CP source into the DUC
// Purpose: on start, latches frame config and rate, settles the DUC/DDC rate ports,
//          passes num_sym*(nfft+cp_len) beats with tlast/symbol markers, then flushes
//          the interpolation chain with zero guard beats.
// Ports:
//   aclk, areset                      clock, synchronous active-high reset
//   start, cfg_*                      frame request and configuration
//   Interp_ratio, decimate_ratio      latched rate to the DUC/DDC
//   S_AXIS_*                          IQ from the sample source
//   M_AXIS_*                          IQ to the DUC (tkeep follows tvalid)
//   sym_start                         first beat (CP start) of each symbol
//   busy, done, err_tlast             status; err_tlast is sticky until the next frame
module duc_frame_scheduler
   import duc_sched_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int LEN_W      = 16,
   parameter int SYM_W      = 8,
   parameter int SETTLE_CYC = 16,
   parameter int GUARD_LEN  = 64
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                start,
   input  logic [SYM_W-1:0]    cfg_num_sym,
   input  logic [LEN_W-1:0]    cfg_nfft,
   input  logic [LEN_W-1:0]    cfg_cp_len,
   input  logic [15:0]         cfg_rate,
   output logic [15:0]         Interp_ratio,
   output logic [15:0]         decimate_ratio,
   input  logic [DATA_W-1:0]   S_AXIS_tdata,
   input  logic                S_AXIS_tvalid,
   input  logic                S_AXIS_tlast,
   output logic                S_AXIS_tready,
   output logic [DATA_W-1:0]   M_AXIS_tdata,
   output logic                M_AXIS_tvalid,
   input  logic                M_AXIS_tready,
   output logic                M_AXIS_tlast,
   output logic [DATA_W/8-1:0] M_AXIS_tkeep,
   output logic                sym_start,
   output logic                busy,
   output logic                done,
   output logic                err_tlast
);

   localparam int             CW          = 16;
   localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0]  GUARD_LAST  = CW'(GUARD_LEN - 1);
   localparam logic [CW-1:0]  CNT_ONE     = CW'(1);

   state_t           state_q,   state_d;
   logic [SYM_W-1:0] num_sym_q, num_sym_d;
   logic [LEN_W:0]   sym_len_q, sym_len_d;
   logic [15:0]      rate_q,    rate_d;
   logic             err_q,     err_d;
   logic [CW-1:0]    settle_q,  settle_d;
   logic [CW-1:0]    guard_q,   guard_d;

   logic cfg_ok, beat, first_beat, last_beat;

   assign cfg_ok = start && (cfg_num_sym != '0) && (cfg_nfft != '0) && (cfg_rate != '0);

   duc_frame_counter #(
      .LEN_W (LEN_W),
      .SYM_W (SYM_W)
   ) u_cnt (
      .clk        (aclk),
      .rst        (areset),
      .clr        (state_q == IDLE),
      .beat       (beat),
      .sym_len    (sym_len_q),
      .num_sym    (num_sym_q),
      .first_beat (first_beat),
      .last_beat  (last_beat)
   );

   always_comb begin
      state_d       = state_q;
      num_sym_d     = num_sym_q;
      sym_len_d     = sym_len_q;
      rate_d        = rate_q;
      err_d         = err_q;
      settle_d      = settle_q;
      guard_d       = guard_q;
      beat          = 1'b0;
      S_AXIS_tready = 1'b0;
      M_AXIS_tvalid = 1'b0;
      M_AXIS_tdata  = '0;
      M_AXIS_tlast  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg_ok) begin
               num_sym_d = cfg_num_sym;
               sym_len_d = {1'b0, cfg_nfft} + {1'b0, cfg_cp_len};
               rate_d    = cfg_rate;
               err_d     = 1'b0;
               settle_d  = '0;
               state_d   = (SETTLE_CYC == 0) ? STREAM : SETTLE;
            end
         end
         SETTLE: begin
            settle_d = settle_q + CNT_ONE;
            if (settle_q == SETTLE_LAST) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            // Zero-latency pass-through; the frame length is set by the count,
            // upstream tlast is only checked against it.
            M_AXIS_tvalid = S_AXIS_tvalid;
            S_AXIS_tready = M_AXIS_tready;
            M_AXIS_tdata  = S_AXIS_tdata;
            M_AXIS_tlast  = last_beat && S_AXIS_tvalid;
            beat          = S_AXIS_tvalid && M_AXIS_tready;
            if (beat) begin
               if (S_AXIS_tlast != last_beat) begin
                  err_d = 1'b1;
               end
               if (last_beat) begin
                  guard_d = '0;
                  state_d = (GUARD_LEN == 0) ? DONE : GUARD;
               end
            end
         end
         GUARD: begin
            M_AXIS_tvalid = 1'b1;
            if (M_AXIS_tready) begin
               guard_d = guard_q + CNT_ONE;
               if (guard_q == GUARD_LAST) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= IDLE;
         num_sym_q <= '0;
         sym_len_q <= '0;
         rate_q    <= DEFAULT_RATE;
         err_q     <= 1'b0;
         settle_q  <= '0;
         guard_q   <= '0;
      end else begin
         state_q   <= state_d;
         num_sym_q <= num_sym_d;
         sym_len_q <= sym_len_d;
         rate_q    <= rate_d;
         err_q     <= err_d;
         settle_q  <= settle_d;
         guard_q   <= guard_d;
      end
   end

   // Guard beats sit at samp_cnt == 0, so the marker is qualified by STREAM.
   assign sym_start      = (state_q == STREAM) && first_beat && S_AXIS_tvalid;
   assign M_AXIS_tkeep   = {(DATA_W/8){M_AXIS_tvalid}};
   assign busy           = (state_q != IDLE) && (state_q != DONE);
   assign done           = (state_q == DONE);
   assign err_tlast      = err_q;
   assign Interp_ratio   = rate_q;
   assign decimate_ratio = rate_q;

endmodule
